cordic_rotation: RTL

//  Iterative CORDIC engine in rotation mode: rotates vector (x_in, y_in) by angle_in.

---
 rtl/cordic_rotation.sv | 139 +++++++++++++
 1 files changed

// File: rtl/cordic_rotation.sv
// Iterative rotation-mode CORDIC: rotates (x_in, y_in) by angle_in, one micro-rotation
// per clock, sequenced by a start/done handshake. Results carry the CORDIC gain K.
//
// state  | meaning
// IDLE   | waiting for start; operands are captured on the start edge
// ROTATE | one micro-rotation per clock, iter = 0 .. ITERATIONS-1
// DONE   | done pulse; x_out/y_out hold the fresh result
module cordic_rotation #(
  parameter int WORD_LENGTH = 16,
  parameter int ITERATIONS  = 14
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic signed [WORD_LENGTH-1:0] x_in,
  input  logic signed [WORD_LENGTH-1:0] y_in,
  input  logic signed [WORD_LENGTH-1:0] angle_in,
  output logic                          busy,
  output logic                          done,
  output logic signed [WORD_LENGTH+1:0] x_out,
  output logic signed [WORD_LENGTH+1:0] y_out
);

  localparam int IW = WORD_LENGTH + 2;
  localparam int ZW = WORD_LENGTH + 1;
  localparam int CW = $clog2(ITERATIONS + 1);
  localparam int UP = (WORD_LENGTH >= 16) ? WORD_LENGTH - 16 : 0;
  localparam int DN = (WORD_LENGTH < 16) ? 16 - WORD_LENGTH : 0;

  // Table is held at 16-bit angle scale (2^15 == pi) and rescaled with rounding for other widths.
  function automatic logic signed [ZW-1:0] atan_lut(input int i);
    int v16;
    case (i)
      0:  v16 = 8192;
      1:  v16 = 4836;
      2:  v16 = 2555;
      3:  v16 = 1297;
      4:  v16 = 651;
      5:  v16 = 326;
      6:  v16 = 163;
      7:  v16 = 81;
      8:  v16 = 41;
      9:  v16 = 20;
      10: v16 = 10;
      11: v16 = 5;
      12: v16 = 3;
      13: v16 = 1;
      14: v16 = 1;
      default: v16 = 0;
    endcase
    return ZW'((((v16 <<< UP) * 2) + (1 <<< DN)) >>> (DN + 1));
  endfunction

  typedef enum logic [1:0] {IDLE, ROTATE, DONE} state_t;
  state_t state, state_nx;

  logic signed [IW-1:0] x_q, y_q, x_nx, y_nx, x_sh, y_sh, x_ext, y_ext;
  logic signed [ZW-1:0] z_q, z_nx, z_ld, atan_i;
  logic [CW-1:0]        iter;
  logic                 pre, last;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE:   if (start) state_nx = ROTATE;
      ROTATE: begin
        busy = 1'b1;
        if (last) state_nx = DONE;
      end
      DONE: begin
        busy     = 1'b1;
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // |angle| > pi/2 is folded by negating the vector and shifting z by pi (MSB flip).
  always_comb begin
    x_ext  = {{2{x_in[WORD_LENGTH-1]}}, x_in};
    y_ext  = {{2{y_in[WORD_LENGTH-1]}}, y_in};
    pre    = angle_in[WORD_LENGTH-1] ^ angle_in[WORD_LENGTH-2];
    z_ld   = pre ? {~angle_in[WORD_LENGTH-1], ~angle_in[WORD_LENGTH-1], angle_in[WORD_LENGTH-2:0]}
                 : {angle_in[WORD_LENGTH-1], angle_in};
    x_sh   = x_q >>> iter;
    y_sh   = y_q >>> iter;
    atan_i = atan_lut(int'(iter));
    if (!z_q[ZW-1]) begin
      x_nx = x_q - y_sh;
      y_nx = y_q + x_sh;
      z_nx = z_q - atan_i;
    end else begin
      x_nx = x_q + y_sh;
      y_nx = y_q - x_sh;
      z_nx = z_q + atan_i;
    end
    last = (iter == CW'(ITERATIONS - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q   <= '0;
      y_q   <= '0;
      z_q   <= '0;
      iter  <= '0;
      x_out <= '0;
      y_out <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          x_q  <= pre ? -x_ext : x_ext;
          y_q  <= pre ? -y_ext : y_ext;
          z_q  <= z_ld;
          iter <= '0;
        end
        ROTATE: begin
          x_q  <= x_nx;
          y_q  <= y_nx;
          z_q  <= z_nx;
          iter <= iter + 1'b1;
          if (last) begin
            x_out <= x_nx;
            y_out <= y_nx;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
